// File: rtl/clb_cfg_pkg.sv
// Shared definitions for the CLB configuration path: load FSM states,
// default frame geometry and the word-count helper.
package clb_cfg_pkg;

  localparam int CFG_BITS_DEFAULT = 64;
  localparam int WORD_W_DEFAULT   = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    CHECK  = 3'd2,
    COMMIT = 3'd3,
    DONE   = 3'd4
  } cfg_load_state_t;

  function automatic int calc_num_words(input int cfg_bits, input int word_w);
    return (cfg_bits + word_w - 1) / word_w;
  endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Shadow register and word counter for the frame loader; optional running
// XOR checksum under CONFIG_FRAME_LOADER_CHECKSUM_EN.
module cfg_word_assembler
  import clb_cfg_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEFAULT,
  parameter int WORD_W   = WORD_W_DEFAULT
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                accept,
  input  logic [WORD_W-1:0]   word,
  output logic [CFG_BITS-1:0] shadow,
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
  output logic                csum_ok,
`endif
  output logic                last_word
);

  localparam int NUM_WORDS = calc_num_words(CFG_BITS, WORD_W);
  localparam int CNT_W     = $clog2(NUM_WORDS + 1);
  localparam int LAST_LO   = (NUM_WORDS - 1) * WORD_W;
  localparam int LAST_BITS = CFG_BITS - LAST_LO;

  logic [CNT_W-1:0]    count_q;
  logic [CFG_BITS-1:0] shadow_q;
  logic                final_data;

  assign final_data = (count_q == CNT_W'(NUM_WORDS - 1));
  assign shadow     = shadow_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else if (clear) begin
      count_q  <= '0;
      shadow_q <= '0;
    end else if (accept) begin
      count_q <= count_q + 1'b1;
      for (int i = 0; i < NUM_WORDS - 1; i++) begin
        if (count_q == CNT_W'(i)) shadow_q[i*WORD_W +: WORD_W] <= word;
      end
      // Ragged final word: only the bits that fit the frame are kept.
      if (final_data) shadow_q[CFG_BITS-1:LAST_LO] <= word[LAST_BITS-1:0];
    end
  end

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
  logic [WORD_W-1:0] word_pad;
  logic [WORD_W-1:0] xor_q;
  logic              csum_ok_q;
  logic              data_phase;

  assign data_phase = (count_q < CNT_W'(NUM_WORDS));
  assign word_pad   = final_data ? WORD_W'(word[LAST_BITS-1:0]) : word;
  assign last_word  = (count_q == CNT_W'(NUM_WORDS));
  assign csum_ok    = csum_ok_q;

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q     <= '0;
      csum_ok_q <= 1'b0;
    end else if (clear) begin
      xor_q     <= '0;
      csum_ok_q <= 1'b0;
    end else if (accept) begin
      if (data_phase) xor_q <= xor_q ^ word_pad;
      else            csum_ok_q <= (word == xor_q);
    end
  end
`else
  assign last_word = final_data;
`endif

endmodule

// File: rtl/config_frame_loader.sv
// Word-serial configuration frame loader: FSM plus commit register driving
// config_out/cen. Optional checksum stage under CONFIG_FRAME_LOADER_CHECKSUM_EN.
module config_frame_loader
  import clb_cfg_pkg::*;
#(
  parameter int CFG_BITS = CFG_BITS_DEFAULT,
  parameter int WORD_W   = WORD_W_DEFAULT
) (
  input  logic                cclk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic                in_valid,
  input  logic [WORD_W-1:0]   in_data,
  output logic                in_ready,
  output logic [CFG_BITS-1:0] config_out,
  output logic                cen,
  output logic                busy,
  output logic                done,
  output logic                err
);

  cfg_load_state_t     state_q, state_d;
  logic                accept, clear, last_word;
  logic [CFG_BITS-1:0] shadow;
  logic [CFG_BITS-1:0] config_q;
  logic                cen_q;

  assign in_ready   = (state_q == LOAD);
  assign accept     = in_valid && in_ready;
  assign clear      = start && ((state_q == IDLE) || (state_q == DONE));
  assign busy       = (state_q == LOAD) || (state_q == CHECK) || (state_q == COMMIT);
  assign done       = (state_q == DONE);
  assign config_out = config_q;
  assign cen        = cen_q;

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
  logic csum_ok;
`endif

  cfg_word_assembler #(
    .CFG_BITS (CFG_BITS),
    .WORD_W   (WORD_W)
  ) u_assembler (
    .cclk      (cclk),
    .rst_n     (rst_n),
    .clear     (clear),
    .accept    (accept),
    .word      (in_data),
    .shadow    (shadow),
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    .csum_ok   (csum_ok),
`endif
    .last_word (last_word)
  );

  // NOTE: next-state starts from a default so no path through the case
  // leaves state_d unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = LOAD;
      LOAD: begin
        if (abort)                   state_d = IDLE;
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
        else if (accept && last_word) state_d = CHECK;
`else
        else if (accept && last_word) state_d = COMMIT;
`endif
      end
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
      CHECK: begin
        if (abort)        state_d = IDLE;
        else if (csum_ok) state_d = COMMIT;
        else              state_d = DONE;
      end
`endif
      COMMIT:  state_d = abort ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // The commit lands even when abort arrives in COMMIT; abort only redirects the FSM.
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n) begin
      config_q <= '0;
      cen_q    <= 1'b0;
    end else begin
      cen_q <= (state_q == COMMIT);
      if (state_q == COMMIT) config_q <= shadow;
    end
  end

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
  logic err_q;
  always_ff @(posedge cclk or negedge rst_n) begin
    if (!rst_n)                                      err_q <= 1'b0;
    else if (clear)                                  err_q <= 1'b0;
    else if ((state_q == CHECK) && !abort && !csum_ok) err_q <= 1'b1;
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: a 64/8 instance and a ragged 20/8 instance.
module tb_config_frame_loader;

  logic        cclk = 1'b0;
  logic        rst_n;
  always #5 cclk = ~cclk;

  logic        start64, abort64, valid64, ready64, cen64, busy64, done64, err64;
  logic [7:0]  data64;
  logic [63:0] cfg64;
  logic        start20, abort20, valid20, ready20, cen20, busy20, done20, err20;
  logic [7:0]  data20;
  logic [19:0] cfg20;

  config_frame_loader #(.CFG_BITS(64), .WORD_W(8)) u_dut64 (
    .cclk(cclk), .rst_n(rst_n), .start(start64), .abort(abort64),
    .in_valid(valid64), .in_data(data64), .in_ready(ready64),
    .config_out(cfg64), .cen(cen64), .busy(busy64), .done(done64), .err(err64)
  );

  config_frame_loader #(.CFG_BITS(20), .WORD_W(8)) u_dut20 (
    .cclk(cclk), .rst_n(rst_n), .start(start20), .abort(abort20),
    .in_valid(valid20), .in_data(data20), .in_ready(ready20),
    .config_out(cfg20), .cen(cen20), .busy(busy20), .done(done20), .err(err20)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [63:0] sb64[$];
  logic [19:0] sb20[$];
  logic [63:0] model_cfg64;
  logic        prev_cen64 = 1'b0;
  logic        prev_cen20 = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every cen pulse is matched against the oldest expected frame.
  always @(negedge cclk) begin
    if (cen64) begin
      check("cen64_back_to_back", {63'd0, prev_cen64}, 64'd0);
      if (sb64.size() == 0) check("cen64_unexpected", {63'd0, cen64}, 64'd0);
      else                  check("cfg64_commit", cfg64, sb64.pop_front());
    end
    if (cen20) begin
      check("cen20_back_to_back", {63'd0, prev_cen20}, 64'd0);
      if (sb20.size() == 0) check("cen20_unexpected", {63'd0, cen20}, 64'd0);
      else                  check("cfg20_commit", {44'd0, cfg20}, {44'd0, sb20.pop_front()});
    end
    prev_cen64 = cen64;
    prev_cen20 = cen20;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send64(input logic [7:0] w);
    int n = 0;
    valid64 = 1'b1;
    data64  = w;
    while (ready64 !== 1'b1 && n < 50) begin @(negedge cclk); n++; end
    if (n >= 50) check("ready64_timeout", {63'd0, ready64}, 64'd1);
    @(negedge cclk);
  endtask

  task automatic send20(input logic [7:0] w);
    int n = 0;
    valid20 = 1'b1;
    data20  = w;
    while (ready20 !== 1'b1 && n < 50) begin @(negedge cclk); n++; end
    if (n >= 50) check("ready20_timeout", {63'd0, ready20}, 64'd1);
    @(negedge cclk);
  endtask

  task automatic pulse_start64;
    start64 = 1'b1;
    @(negedge cclk);
    start64 = 1'b0;
  endtask

  // A nonzero delta corrupts the checksum word; only delta==0 expects a commit.
  task automatic load64(input logic [7:0] w[8], input logic [7:0] delta);
    logic [63:0] exp;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i*8 +: 8] = w[i];
    pulse_start64();
    if (delta == 8'h00) begin
      sb64.push_back(exp);
      model_cfg64 = exp;
    end
    for (int i = 0; i < 8; i++) send64(w[i]);
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = '0;
      for (int i = 0; i < 8; i++) x ^= w[i];
      send64(x ^ delta);
    end
`endif
    valid64 = 1'b0;
  endtask

  task automatic load20(input logic [7:0] w[3], input logic [7:0] delta);
    logic [23:0] full;
    logic [19:0] exp;
    full = {w[2], w[1], w[0]};
    exp  = full[19:0];
    start20 = 1'b1;
    @(negedge cclk);
    start20 = 1'b0;
    if (delta == 8'h00) sb20.push_back(exp);
    for (int i = 0; i < 3; i++) begin
      send20(w[i]);
      if (i < 2) begin
        valid20 = 1'b0;
        data20  = 8'h55;
        repeat (3) begin
          @(negedge cclk);
          check("ready20_gap", {63'd0, ready20}, 64'd1);
        end
      end
    end
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    begin
      logic [23:0] padded;
      padded = {4'h0, exp};
      send20(padded[7:0] ^ padded[15:8] ^ padded[23:16] ^ delta);
    end
`endif
    valid20 = 1'b0;
  endtask

  logic [7:0] wa[8];
  logic [7:0] wb[3];

  initial begin
    rst_n = 1'b0;
    {start64, abort64, valid64, start20, abort20, valid20} = '0;
    data64 = '0;
    data20 = '0;
    model_cfg64 = '0;
    repeat (2) @(negedge cclk);
    check("rst_cfg64",   cfg64, 64'd0);
    check("rst_ready64", {63'd0, ready64}, 64'd0);
    check("rst_flags64", {60'd0, cen64, busy64, done64, err64}, 64'd0);
    check("rst_cfg20",   {44'd0, cfg20}, 64'd0);
    rst_n = 1'b1;
    @(negedge cclk);

    // Nominal 64-bit load with latency checks around the commit.
    for (int i = 0; i < 8; i++) wa[i] = 8'(i + 1);
    load64(wa, 8'h00);
    check("nom_cen_early", {63'd0, cen64}, 64'd0);
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    @(negedge cclk);
    check("nom_cen_check", {63'd0, cen64}, 64'd0);
`endif
    @(negedge cclk);
    check("nom_cen_pulse", {63'd0, cen64}, 64'd1);
    check("nom_cfg",       cfg64, 64'h0807060504030201);
    @(negedge cclk);
    check("nom_cen_low",   {63'd0, cen64}, 64'd0);
    check("nom_done_busy", {62'd0, done64, busy64}, 64'd2);
    check("nom_err",       {63'd0, err64}, 64'd0);

    // Ragged 20-bit frame with stalls between words.
    wb[0] = 8'hAA; wb[1] = 8'hBB; wb[2] = 8'hFF;
    load20(wb, 8'h00);
    repeat (4) @(negedge cclk);
    check("rag_cfg20", {44'd0, cfg20}, 64'h0FBBAA);
    check("rag_done20", {63'd0, done20}, 64'd1);

    // Abort after four words leaves the live frame alone.
    for (int i = 0; i < 8; i++) wa[i] = 8'h11;
    load64(wa, 8'h00);
    repeat (3) @(negedge cclk);
    pulse_start64();
    for (int i = 0; i < 4; i++) send64(8'(8'h20 + i));
    valid64 = 1'b0;
    abort64 = 1'b1;
    @(negedge cclk);
    abort64 = 1'b0;
    check("abort_idle", {61'd0, busy64, done64, ready64}, 64'd0);
    repeat (4) @(negedge cclk);
    check("abort_cfg_kept", cfg64, 64'h1111111111111111);
    for (int i = 0; i < 8; i++) wa[i] = 8'(8'h30 + i);
    load64(wa, 8'h00);
    repeat (4) @(negedge cclk);
    check("abort_reload", cfg64, model_cfg64);

    // start pulsed mid-LOAD must not restart the frame.
    for (int i = 0; i < 8; i++) wa[i] = 8'(8'hA0 + 3 * i);
    pulse_start64();
    sb64.push_back({wa[7], wa[6], wa[5], wa[4], wa[3], wa[2], wa[1], wa[0]});
    model_cfg64 = {wa[7], wa[6], wa[5], wa[4], wa[3], wa[2], wa[1], wa[0]};
    for (int i = 0; i < 3; i++) send64(wa[i]);
    valid64 = 1'b0;
    start64 = 1'b1;
    @(negedge cclk);
    start64 = 1'b0;
    check("midstart_busy", {63'd0, busy64}, 64'd1);
    for (int i = 3; i < 8; i++) send64(wa[i]);
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    send64(wa[0] ^ wa[1] ^ wa[2] ^ wa[3] ^ wa[4] ^ wa[5] ^ wa[6] ^ wa[7]);
`endif
    valid64 = 1'b0;
    repeat (4) @(negedge cclk);
    check("midstart_cfg", cfg64, model_cfg64);

    // Asynchronous reset between edges after three words.
    pulse_start64();
    for (int i = 0; i < 3; i++) send64(8'(8'h40 + i));
    valid64 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_cfg",   cfg64, 64'd0);
    check("arst_flags", {60'd0, ready64, cen64, busy64, done64}, 64'd0);
    #1;
    start64 = 1'b1;
    rst_n   = 1'b1;
    @(negedge cclk);
    start64 = 1'b0;
    check("arst_restart", {62'd0, busy64, ready64}, 64'd3);
    for (int i = 0; i < 8; i++) wa[i] = 8'(8'h50 + i);
    sb64.push_back({wa[7], wa[6], wa[5], wa[4], wa[3], wa[2], wa[1], wa[0]});
    model_cfg64 = {wa[7], wa[6], wa[5], wa[4], wa[3], wa[2], wa[1], wa[0]};
    for (int i = 0; i < 8; i++) send64(wa[i]);
`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    send64(wa[0] ^ wa[1] ^ wa[2] ^ wa[3] ^ wa[4] ^ wa[5] ^ wa[6] ^ wa[7]);
`endif
    valid64 = 1'b0;
    repeat (4) @(negedge cclk);
    check("arst_cfg_after", cfg64, model_cfg64);

`ifdef CONFIG_FRAME_LOADER_CHECKSUM_EN
    // Wrong checksum 0x09: no commit, err raised, live frame kept.
    for (int i = 0; i < 8; i++) wa[i] = 8'(i + 1);
    load64(wa, 8'h01);
    repeat (3) @(negedge cclk);
    check("csum_bad_err",  {63'd0, err64}, 64'd1);
    check("csum_bad_done", {63'd0, done64}, 64'd1);
    check("csum_bad_cfg",  cfg64, model_cfg64);
    // Correct checksum 0x08 commits and clears err.
    load64(wa, 8'h00);
    repeat (4) @(negedge cclk);
    check("csum_ok_err", {63'd0, err64}, 64'd0);
    check("csum_ok_cfg", cfg64, 64'h0807060504030201);
`endif

    repeat (3) @(negedge cclk);
    check("sb64_drained", 64'(sb64.size()), 64'd0);
    check("sb20_drained", 64'(sb20.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
